// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial N-bit subtractor. It computes diff = a - b - bin one bit per
//   clock, starting at the LSB. A single borrow flip-flop feeds a
//   full-subtractor cell.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  request; sampled only in IDLE or DONE
//     a, b   minuend and subtrahend, captured on an accepted start
//     bin    borrow-in, captured on an accepted start
//     busy   high while the operation is running
//     done   one-cycle pulse when diff/bout/ovf update
//     diff   a - b - bin modulo 2^WIDTH
//     bout   final borrow-out (unsigned a < b + bin)
//     ovf    two's-complement overflow
//
//   State table:
//     IDLE | waiting for start; results held
//     RUN  | one bit processed per edge, cnt counts 0..WIDTH-1
//     DONE | results just published; start here chains the next operation

// One-bit full subtractor built from gate primitives:
//   d  = x ^ y ^ bi
//   bo = (~x & y) | (~(x ^ y) & bi)
module serial_subtractor_fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic t, xn, tn, p, q;

  xor g_x0 (t, x, y);
  xor g_x1 (d, t, bi);
  not g_n0 (xn, x);
  and g_a0 (p, xn, y);
  not g_n1 (tn, t);
  and g_a1 (q, tn, bi);
  or  g_o0 (bo, p, q);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             a_msb, b_msb;
  logic             d, brw_nxt;
  logic             accept, last;

  serial_subtractor_fs_cell u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (brw),
    .d  (d),
    .bo (brw_nxt)
  );

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      brw   <= bin;
      cnt   <= '0;
      sd    <= '0;
      // The MSBs are kept separately because sa/sb are shifted away by the end.
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sd  <= {d, sd[WIDTH-1:1]};
      brw <= brw_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        // On the last bit, d is the result MSB and brw_nxt is the final borrow.
        diff <= {d, sd[WIDTH-1:1]};
        bout <= brw_nxt;
        ovf  <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor. An 8-bit instance covers the directed
// scenarios and a 4-bit instance is swept exhaustively. Expected results are
// queued when stimulus is driven, then popped and compared when done pulses.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  int   checks = 0;
  int   errors = 0;
  int   done4_cnt = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic [7:0] last_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  function automatic exp_t model8(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    exp_t e;
    logic [8:0] full;
    full = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    e.d  = full[7:0];
    e.bo = full[8];
    e.ov = (ma[7] != mb[7]) && (full[7] != ma[7]);
    return e;
  endfunction

  function automatic exp_t model4(input logic [3:0] ma, input logic [3:0] mb, input logic mbin);
    exp_t e;
    logic [4:0] full;
    full = {1'b0, ma} - {1'b0, mb} - {4'd0, mbin};
    e.d  = {4'd0, full[3:0]};
    e.bo = full[4];
    e.ov = (ma[3] != mb[3]) && (full[3] != ma[3]);
    return e;
  endfunction

  // Scoreboard monitors: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected_done: diff=%h with nothing expected", diff);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if ({diff, bout, ovf} !== {e.d, e.bo, e.ov}) begin
          errors++;
          $display("FAIL sb8_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                   diff, bout, ovf, e.d, e.bo, e.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      done4_cnt++;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected_done: diff=%h", diff4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if ({diff4, bout4, ovf4} !== {e.d[3:0], e.bo, e.ov}) begin
          errors++;
          $display("FAIL sb4_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                   diff4, bout4, ovf4, e.d[3:0], e.bo, e.ov);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
    end
    last_diff = '0;
  endtask

  // Single operation with a start pulse. It checks the busy window, diff
  // stability while busy, and when done appears.
  task automatic test_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tbin);
    exp_t e;
    e = model8(ta, tb2, tbin);
    q8.push_back(e);
    a = ta; b = tb2; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL op_busy cycle %0d: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      checks++;
      if (diff !== last_diff) begin
        errors++;
        $display("FAIL op_diff_stable cycle %0d: got %h, want %h", i, diff, last_diff);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL op_done_timing: got done=%b busy=%b, want 1 0", done, busy);
    end
    last_diff = e.d;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL op_done_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    q8.push_back(model8(8'h10, 8'h0F, 1'b1));
    q8.push_back(model8(8'h03, 8'h05, 1'b0));
    a = 8'h10; b = 8'h0F; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin a = 8'h03; b = 8'h05; bin = 1'b0; end
    repeat (8) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: got done=%b, want 1", done);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: got busy=%b done=%b, want 1 0", busy, done);
    end
    repeat (7) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: got done=%b, want 1", done);
    end
    last_diff = 8'hFE;
    @(negedge clk);
  endtask

  task automatic test_ignored_start_and_reset();
    q8.push_back(model8(8'h20, 8'h10, 1'b0));
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_done: got done=%b, want 1", done);
    end
    @(negedge clk);

    // Start a new run, then reset it mid-flight; nothing may be published.
    a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    last_diff = '0;
  endtask

  task automatic test_exhaustive4();
    bit seen;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
          q4.push_back(model4(4'(ia), 4'(ib), 1'(ic)));
          @(posedge clk);
          #1 start4 = 1'b0;
          seen = 1'b0;
          for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
          end
          if (!seen) begin
            checks++;
            errors++;
            $display("FAIL w4_timeout: a=%h b=%h bin=%0d got no done, want done", ia, ib, ic);
          end
        end
    @(negedge clk);
    checks++;
    if (done4_cnt !== 512) begin
      errors++;
      $display("FAIL w4_done_count: got %0d, want 512", done4_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_op(8'h5A, 8'h3C, 1'b0);
    test_op(8'h00, 8'h01, 1'b0);
    test_op(8'h80, 8'h01, 1'b0);
    test_op(8'h7F, 8'hFF, 1'b1);
    test_back_to_back();
    test_ignored_start_and_reset();
    test_exhaustive4();
    repeat (2) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q8.size(), q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b - bin, one bit per clock, LSB first.
- One borrow flip-flop feeds a full-subtractor cell built from the gate-level primitives already in the codebase.
- Counterpart to the combinational adder path; reused where area matters more than latency.
- start/busy/done handshake; result held in output registers until the next accepted start.

Parameters:
- WIDTH, 8: operand and result width in bits, ≥ 2.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend, captured on an accepted start.
- b  input  WIDTH  subtrahend, captured on an accepted start.
- bin  input  1  borrow-in, captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result registers update.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out (unsigned a < b + bin).
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time including mid-RUN):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow FF and counter all cleared.
  - No partial result is ever published.
- FSM states and transitions:
  - IDLE -(start)-> RUN.
  - RUN -(cnt==WIDTH-1)-> DONE.
  - DONE -(start)-> RUN.
  - DONE -(!start)-> IDLE.
- Accepted start (edge E, state IDLE or DONE):
  - sa<=a, sb<=b, brw<=bin, cnt<=0, sd<=0.
  - busy=1 from E.
- RUN, each edge, operating on bit0 of sa/sb:
  - d = sa[0]^sb[0]^brw.
  - brw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw).
  - sa, sb shift right one place.
  - sd shifts right with d inserted at the MSB.
  - cnt++.
- Completion (edge E+WIDTH, last bit processed):
  - diff <= final sd.
  - bout <= final brw.
  - ovf <= (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - done=1 and busy=0 for exactly the cycle following that edge.
- Latency: start sampled at edge E → done high after edge E+WIDTH. Throughput: one operation per WIDTH+1 cycles. A start held high in DONE gives back-to-back operations with no IDLE cycle.
- start while busy=1: ignored. Operands are not re-captured; no error indication.
- diff/bout/ovf: change only at a completion edge or on reset; stable while busy.
- done: never asserted outside the completion cycle; never asserted on reset release.
- Arithmetic: unsigned modulo 2^WIDTH. bout=1 iff a < b+bin as unsigned integers.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, single start pulse → busy for 8 cycles; done on the 9th cycle after start; diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
  - Then start held high through DONE with a=0x03, b=0x05 → second run begins with no IDLE cycle; diff=0xFE, bout=1.
- Start pulse issued mid-RUN with different operands → ignored; the original result is delivered.
  - Then rst_n=0 at cycle 4 of a new run → immediate busy=0, done=0, diff=0.
  - No done pulse after reset release.
- WIDTH=4 exhaustive: all a, b in 0..15 and bin in {0,1} (512 cases) vs behavioural model of diff/bout/ovf → zero mismatches; done count equals 512.
